piano_envelope: RTL and testbench

Output stage placed directly downstream of the piano note selector. It consumes the selected note code and raw square-wave tone, and applies an attack/decay/sustain/release amplitude envelope. Amplitude is applied by 8-bit PWM gating, and the block drives the speaker pin. When a key is released, the tone continues at the last measured pitch while the level fades out.

---
 rtl/piano_envelope.sv | 195 +++++++++++++++++++
 tb/tb_piano_envelope.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piano_envelope.sv
// ADSR amplitude envelope with 8-bit PWM gating for the piano speaker output.
// Optional feature macro: PIANO_RELEASE_TONE_EN (pitch measurement, tone regenerator, RELEASE state).
module piano_envelope #(
   parameter int          TICK_DIV      = 50000,
   parameter int          ATTACK_STEP   = 8,
   parameter int          DECAY_STEP    = 2,
   parameter int          SUSTAIN_LEVEL = 160,
   parameter int          RELEASE_STEP  = 4,
   parameter int          HP_W          = 20,
   parameter logic [3:0]  NOTE_NONE     = 4'd0
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] note,
   input  logic       FREQ,
   output logic       AUDIO,
   output logic [7:0] level,
   output logic [2:0] env_state,
   output logic       active
);

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } env_state_t;

   env_state_t    state, state_nxt;
   logic [7:0]    level_nxt;
   logic [3:0]    note_q;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [7:0]    pwm_cnt;
   logic          tone;
   logic          note_none;
   logic          note_chg;

   assign note_none = (note == NOTE_NONE);
   assign note_chg  = (note != note_q);
   assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
   assign env_state = state;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Saturating level steps, computed at 9 bits so they never wrap.
   logic [8:0] att_sum, dec_diff;
   logic [7:0] att_lvl, dec_lvl;
   assign att_sum  = {1'b0, level} + 9'(ATTACK_STEP);
   assign att_lvl  = att_sum[8] ? 8'd255 : att_sum[7:0];
   assign dec_diff = {1'b0, level} - 9'(DECAY_STEP);
   assign dec_lvl  = (dec_diff[8] || (dec_diff[7:0] < 8'(SUSTAIN_LEVEL))) ?
                     8'(SUSTAIN_LEVEL) : dec_diff[7:0];

`ifdef PIANO_RELEASE_TONE_EN
   logic [8:0] rel_diff;
   logic [7:0] rel_lvl;
   assign rel_diff = {1'b0, level} - 9'(RELEASE_STEP);
   assign rel_lvl  = rel_diff[8] ? 8'd0 : rel_diff[7:0];
`endif

   always_comb begin
      state_nxt = state;
      level_nxt = level;
      if (tick) begin
         case (state)
            S_ATTACK: level_nxt = att_lvl;
            S_DECAY:  level_nxt = dec_lvl;
`ifdef PIANO_RELEASE_TONE_EN
            S_RELEASE: level_nxt = rel_lvl;
`endif
            default: ;
         endcase
      end
      // Note events take priority over level-driven transitions.
      case (state)
         S_IDLE: begin
            if (!note_none) state_nxt = S_ATTACK;
         end
         S_ATTACK, S_DECAY, S_SUSTAIN: begin
            if (note_none) begin
`ifdef PIANO_RELEASE_TONE_EN
               state_nxt = S_RELEASE;
`else
               state_nxt = S_IDLE;
               level_nxt = 8'd0;
`endif
            end else if (note_chg) begin
               state_nxt = S_ATTACK;
            end else if (tick && (state == S_ATTACK) && (att_lvl == 8'd255)) begin
               state_nxt = S_DECAY;
            end else if (tick && (state == S_DECAY) && (dec_lvl == 8'(SUSTAIN_LEVEL))) begin
               state_nxt = S_SUSTAIN;
            end
         end
`ifdef PIANO_RELEASE_TONE_EN
         S_RELEASE: begin
            if (!note_none) begin
               state_nxt = S_ATTACK;
            end else if (tick && (rel_lvl == 8'd0)) begin
               state_nxt = S_IDLE;
            end
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state  <= S_IDLE;
         level  <= 8'd0;
         active <= 1'b0;
         note_q <= NOTE_NONE;
      end else begin
         state  <= state_nxt;
         level  <= level_nxt;
         active <= (state_nxt != S_IDLE);
         note_q <= note;
      end
   end

`ifdef PIANO_RELEASE_TONE_EN
   logic            freq_q;
   logic            freq_edge;
   logic [HP_W-1:0] hp_cnt;
   logic [HP_W-1:0] half_period;
   logic [HP_W-1:0] regen_cnt;
   logic            regen_tone;
   logic            hp_ok;

   assign freq_edge = FREQ ^ freq_q;
   assign hp_ok     = (half_period != '0) && (half_period != '1);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         freq_q      <= 1'b0;
         hp_cnt      <= '0;
         half_period <= '0;
      end else begin
         freq_q <= FREQ;
         if (freq_edge) begin
            hp_cnt <= HP_W'(1);
            if (!note_none) half_period <= hp_cnt;
         end else if (hp_cnt != '1) begin
            hp_cnt <= hp_cnt + 1'b1;
         end
      end
   end

   // Regenerator restarts high on RELEASE entry and keeps the last measured pitch.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         regen_cnt  <= '0;
         regen_tone <= 1'b0;
      end else if ((state != S_RELEASE) && (state_nxt == S_RELEASE)) begin
         regen_cnt  <= HP_W'(1);
         regen_tone <= 1'b1;
      end else if (state == S_RELEASE) begin
         if (regen_cnt >= half_period) begin
            regen_cnt  <= HP_W'(1);
            regen_tone <= ~regen_tone;
         end else begin
            regen_cnt <= regen_cnt + 1'b1;
         end
      end
   end

   assign tone = (state == S_RELEASE) ? (regen_tone & hp_ok) : FREQ;
`else
   assign tone = FREQ;
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pwm_cnt <= 8'd0;
         AUDIO   <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         AUDIO   <= tone & (pwm_cnt < level);
      end
   end

endmodule

// File: tb/tb_piano_envelope.sv
// Bench for piano_envelope: directed test-plan sequences, then randomized notes checked cycle-by-cycle.
module tb_piano_envelope;
  localparam int TD = 4;
  localparam int AS = 64;
  localparam int DS = 32;
  localparam int SL = 160;
  localparam int RS = 64;
  localparam int HW = 20;
  localparam logic [3:0] NONE = 4'd0;
  localparam int HPMAX = (1 << HW) - 1;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] note;
  logic       FREQ;
  logic       AUDIO;
  logic [7:0] level;
  logic [2:0] env_state;
  logic       active;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 CLK = ~CLK;

  piano_envelope #(
    .TICK_DIV(TD), .ATTACK_STEP(AS), .DECAY_STEP(DS), .SUSTAIN_LEVEL(SL),
    .RELEASE_STEP(RS), .HP_W(HW), .NOTE_NONE(NONE)
  ) dut (
    .CLK(CLK), .RESET(RESET), .note(note), .FREQ(FREQ),
    .AUDIO(AUDIO), .level(level), .env_state(env_state), .active(active)
  );

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural reference model: plain integer arithmetic on the envelope rules
  int m_state, m_level, m_tcnt, m_pwm, m_audio, m_prev_freq;
  int m_e, m_last_edge, m_hp, m_rel_start, m_lvl, m_nst;
  logic [3:0] m_prev_note;
  bit m_tick, m_tone, m_none;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_state = 0; m_level = 0; m_tcnt = 0; m_pwm = 0; m_audio = 0;
      m_prev_note = NONE; m_prev_freq = 0; m_e = 0; m_last_edge = 1;
      m_hp = 0; m_rel_start = 0;
    end else begin
      m_e++;
      m_tick = (m_tcnt == TD - 1);
      m_tcnt = (m_tcnt + 1) % TD;
`ifdef PIANO_RELEASE_TONE_EN
      if (m_state == 4)
        m_tone = (m_hp == 0 || m_hp == HPMAX) ? 1'b0 : ((((m_e - 1 - m_rel_start) / m_hp) % 2) == 0);
      else
        m_tone = FREQ;
`else
      m_tone = FREQ;
`endif
      m_audio = (m_tone && (m_pwm < m_level)) ? 1 : 0;
      m_pwm = (m_pwm + 1) % 256;
      if (int'(FREQ) != m_prev_freq) begin
        if (note != NONE) m_hp = (m_e - m_last_edge > HPMAX) ? HPMAX : m_e - m_last_edge;
        m_last_edge = m_e;
      end
      m_prev_freq = int'(FREQ);
      m_lvl = m_level;
      if (m_tick) begin
        if (m_state == 1) m_lvl = (m_lvl + AS > 255) ? 255 : m_lvl + AS;
        else if (m_state == 2) m_lvl = (m_lvl - DS < SL) ? SL : m_lvl - DS;
        else if (m_state == 4) m_lvl = (m_lvl - RS < 0) ? 0 : m_lvl - RS;
      end
      m_nst = m_state;
      m_none = (note == NONE);
      if (m_state == 0) begin
        if (!m_none) m_nst = 1;
      end else if (m_state == 4) begin
        if (!m_none) m_nst = 1;
        else if (m_tick && m_lvl == 0) m_nst = 0;
      end else begin
        if (m_none) begin
`ifdef PIANO_RELEASE_TONE_EN
          m_nst = 4;
          m_rel_start = m_e;
`else
          m_nst = 0;
          m_lvl = 0;
`endif
        end else if (note != m_prev_note) m_nst = 1;
        else if (m_tick && m_state == 1 && m_lvl == 255) m_nst = 2;
        else if (m_tick && m_state == 2 && m_lvl == SL) m_nst = 3;
      end
      m_state = m_nst;
      m_level = m_lvl;
      m_prev_note = note;
    end
  end

  // scoreboard compare on the falling edge, every cycle out of reset
  always @(negedge CLK) begin
    if (!RESET) begin
      check("env_state", int'(env_state), m_state);
      check("level", int'(level), m_level);
      check("active", int'(active), (m_state != 0) ? 1 : 0);
      check("AUDIO", int'(AUDIO), m_audio);
    end
  end

  // driver: FREQ square wave with half-period 8+2*code clocks
  int gcnt = 0;
  bit freq_hold = 0;

  function automatic int hp_of(logic [3:0] n);
    return 8 + 2 * int'(n);
  endfunction

  task automatic cyc(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (note == NONE) FREQ = 1'b0;
      else if (freq_hold) FREQ = 1'b1;
      else begin
        gcnt++;
        if (gcnt >= hp_of(note)) begin
          FREQ = ~FREQ;
          gcnt = 0;
        end
      end
    end
  endtask

  task automatic set_note(logic [3:0] n);
    note = n;
    gcnt = 0;
    FREQ = 1'b0;
  endtask

  task automatic next_level(int exp, string name);
    int last;
    int n;
    last = int'(level);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (int'(level) == last && n < 4 * TD);
    check(name, int'(level), exp);
  endtask

  task automatic wait_state(int s, int budget, string name);
    int n;
    n = 0;
    while (int'(env_state) != s && n < budget) begin
      cyc(1);
      n++;
    end
    check(name, int'(env_state), s);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_state"}, int'(env_state), 0);
    check({tag, "_active"}, int'(active), 0);
    check({tag, "_audio"}, int'(AUDIO), 0);
  endtask

  initial begin
    int cnt;
    logic [3:0] n;
    RESET = 1'b1;
    note = NONE;
    FREQ = 1'b0;
    cyc(3);
    RESET = 1'b0;
    check_reset_outputs("reset");

    // attack from idle with C4 (code 1, half-period 10)
    set_note(4'd1);
    cyc(1);
    check("attack_entry", int'(env_state), 1);
    check("attack_active", int'(active), 1);
    next_level(64, "att_64");
    next_level(128, "att_128");
    next_level(192, "att_192");
    next_level(255, "att_255");
    check("decay_entry", int'(env_state), 2);
    next_level(223, "dec_223");
    next_level(191, "dec_191");
    next_level(160, "dec_160");
    check("sustain_entry", int'(env_state), 3);
    cyc(100 * TD);
    check("sustain_hold", int'(level), 160);

    // PWM duty with tone held high
    freq_hold = 1;
    FREQ = 1'b1;
    cyc(2);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      cnt += int'(AUDIO);
    end
    check("pwm_duty_160", cnt, 160);
    freq_hold = 0;
    cyc(30);

`ifdef PIANO_RELEASE_TONE_EN
    set_note(NONE);
    next_level(96, "rel_96");
    check("release_state", int'(env_state), 4);
    next_level(32, "rel_32");
    next_level(0, "rel_0");
    check("release_idle", int'(env_state), 0);
    check("release_inactive", int'(active), 0);

    // retrigger during release at level 96
    set_note(4'd1);
    wait_state(3, 200, "sustain_again");
    set_note(NONE);
    next_level(96, "retrig_rel_96");
    set_note(4'd3);
    cyc(1);
    check("retrig_state", int'(env_state), 1);
    check("retrig_level", int'(level), 96);
    next_level(160, "retrig_160");
`else
    set_note(NONE);
    cyc(1);
    check("off_idle", int'(env_state), 0);
    check("off_level", int'(level), 0);
    check("off_inactive", int'(active), 0);
    cyc(1);
    check("off_audio", int'(AUDIO), 0);
    set_note(4'd3);
    cyc(1);
    check("off_reattack", int'(env_state), 1);
`endif

    // asynchronous reset in DECAY, then restart with note held
    wait_state(2, 200, "decay_before_reset");
    cyc(1);
    #2 RESET = 1'b1;
    #1 check_reset_outputs("async_reset");
    cyc(2);
    #2 RESET = 1'b0;
    cyc(1);
    check("restart_state", int'(env_state), 1);
    check("restart_level", int'(level), 0);
    next_level(64, "restart_64");

    // randomized note sequences against the model
    for (int ep = 0; ep < 90; ep++) begin
      if ($urandom_range(0, 9) < 3) n = NONE;
      else n = 4'($urandom_range(1, 15));
      set_note(n);
      cyc($urandom_range(2, 70));
      if ($urandom_range(0, 24) == 0) begin
        #2 RESET = 1'b1;
        #1 check("rand_reset_level", int'(level), 0);
        cyc(1);
        #2 RESET = 1'b0;
      end
    end
    set_note(NONE);
    cyc(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
